// File: rtl/stream_mux_4to1_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_4to1_rr
//
// Merges four valid/ready streams into one registered output stream. Arbitration
// is round-robin at packet granularity. Once a channel wins with a non-final
// beat, it keeps the grant until its din_last beat is accepted. Each output beat
// carries a sel tag with its source channel, so a 1-to-4 demux can route it back.
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | between packets: the next source is chosen by rotating priority from ptr
// LOCK  | mid-packet: only lock_ch is served until its din_last beat is taken
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   din_valid  : [3:0] per-channel beat offered
//   din        : [4*WIDTH-1:0] channel i data at din[i*WIDTH +: WIDTH]
//   din_last   : [3:0] per-channel final-beat marker
//   din_ready  : [3:0] per-channel accept (at most one bit set)
//   dout_valid : output register holds a beat
//   dout       : [WIDTH-1:0] held beat data
//   sel        : [1:0] source channel of the held beat
//   dout_last  : held beat's last flag
//   dout_ready : downstream takes the held beat when dout_valid is also high
// -----------------------------------------------------------------------------
module stream_mux_4to1_rr #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         din_valid,
    input  logic [4*WIDTH-1:0] din,
    input  logic [3:0]         din_last,
    output logic [3:0]         din_ready,
    output logic               dout_valid,
    output logic [WIDTH-1:0]   dout,
    output logic [1:0]         sel,
    output logic               dout_last,
    input  logic               dout_ready
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_lock_ch;
    logic             r_dout_valid;
    logic [WIDTH-1:0] r_dout;
    logic [1:0]       r_sel;
    logic             r_dout_last;

    logic             w_load_en;
    logic [3:0]       w_rot;
    logic [1:0]       w_offset;
    logic [1:0]       w_winner;
    logic             w_any_valid;
    logic [1:0]       w_grant_ch;
    logic             w_grant_en;
    logic             w_accept;
    logic [WIDTH-1:0] w_acc_data;
    logic             w_acc_last;

    // The output register can take a beat when it is empty or is being drained.
    assign w_load_en   = !r_dout_valid || dout_ready;
    assign w_any_valid = |din_valid;

    // Rotate din_valid so that bit k corresponds to channel (ptr + k) mod 4.
    // The lowest set bit then gives the distance from ptr to the winner.
    always_comb begin
        w_rot = din_valid;
        case (r_ptr)
            2'd0: w_rot = din_valid;
            2'd1: w_rot = {din_valid[0],   din_valid[3:1]};
            2'd2: w_rot = {din_valid[1:0], din_valid[3:2]};
            2'd3: w_rot = {din_valid[2:0], din_valid[3]};
            default: w_rot = din_valid;
        endcase
    end

    always_comb begin
        w_offset = 2'd0;
        if (w_rot[0])
            w_offset = 2'd0;
        else if (w_rot[1])
            w_offset = 2'd1;
        else if (w_rot[2])
            w_offset = 2'd2;
        else if (w_rot[3])
            w_offset = 2'd3;
    end

    // 2-bit addition wraps channel 3 back to channel 0.
    assign w_winner = r_ptr + w_offset;

    // In LOCK the grant stays on lock_ch even while that channel has no beat.
    // This keeps other channels out until the packet completes.
    assign w_grant_ch = (r_state == ST_LOCK) ? r_lock_ch : w_winner;
    assign w_grant_en = !rst && w_load_en && ((r_state == ST_LOCK) || w_any_valid);

    assign din_ready  = w_grant_en ? (4'b0001 << w_grant_ch) : 4'b0000;
    assign w_accept   = w_grant_en && din_valid[w_grant_ch];
    assign w_acc_data = din[w_grant_ch*WIDTH +: WIDTH];
    assign w_acc_last = din_last[w_grant_ch];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= 2'd0;
            r_lock_ch    <= 2'd0;
            r_dout_valid <= 1'b0;
            r_dout       <= '0;
            r_sel        <= 2'd0;
            r_dout_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dout_valid <= 1'b1;
                r_dout       <= w_acc_data;
                r_sel        <= w_grant_ch;
                r_dout_last  <= w_acc_last;
                case (r_state)
                    ST_IDLE: begin
                        if (w_acc_last) begin
                            r_ptr <= w_grant_ch + 2'd1;
                        end else begin
                            r_state   <= ST_LOCK;
                            r_lock_ch <= w_grant_ch;
                        end
                    end
                    ST_LOCK: begin
                        if (w_acc_last) begin
                            r_state <= ST_IDLE;
                            r_ptr   <= r_lock_ch + 2'd1;
                        end
                    end
                endcase
            end else if (dout_ready) begin
                // Popped with no replacement: data fields keep their last values.
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign dout_valid = r_dout_valid;
    assign dout       = r_dout;
    assign sel        = r_sel;
    assign dout_last  = r_dout_last;

endmodule

// File: doc/stream_mux_4to1_rr.md
STREAM_MUX_4TO1_RR -- requirements
Module: stream_mux_4to1_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data width per channel.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port din_valid, input, 4 bits: bit i high means channel i offers a beat.
REQ-005 SHALL have port din, input, 4*WIDTH bits: channel i data at din[i*WIDTH +: WIDTH].
REQ-006 SHALL have port din_last, input, 4 bits: bit i marks the final beat of a channel-i packet.
REQ-007 SHALL have port din_ready, output, 4 bits: bit i high means the channel-i beat is accepted this cycle.
REQ-008 SHALL have port dout_valid, output, 1 bit: the output register holds a beat.
REQ-009 SHALL have port dout, output, WIDTH bits: registered data of the held beat.
REQ-010 SHALL have port sel, output, 2 bits: source channel index of the held beat.
REQ-011 SHALL have port dout_last, output, 1 bit: registered din_last of the held beat.
REQ-012 SHALL have port dout_ready, input, 1 bit: the downstream accepts the held beat when dout_valid and dout_ready are both high.

Function
REQ-013 SHALL be the merge counterpart of the 1-to-4 demux: it interleaves 4 valid/ready streams into one stream, and sel tags each beat so the demux can route it back.
REQ-014 SHALL define load_en = !dout_valid || dout_ready, meaning the output register can take a new beat this cycle.
REQ-015 SHALL accept a beat on channel i only when din_valid[i] and din_ready[i] are both high; at most one din_ready bit SHALL be high in any cycle.
REQ-016 SHALL implement a two-state FSM:
- IDLE: selects a new packet source.
- LOCK: stays with the chosen channel until that packet completes.
REQ-017 In IDLE, the winner SHALL be the first channel with din_valid set, searching ptr, ptr+1, ... (mod 4).
- din_ready[winner] = load_en.
- No din_ready bit is set if no channel has din_valid set.
REQ-018 SHALL behave as follows on an IDLE accept:
- din_last = 1: stay in IDLE and set ptr = winner+1 (mod 4).
- din_last = 0: go to LOCK and set lock_ch = winner.
REQ-019 In LOCK, din_ready[lock_ch] SHALL equal load_en, and all other din_ready bits SHALL be 0 regardless of din_valid.
REQ-020 In LOCK, an accepted beat with din_last = 1 SHALL return the FSM to IDLE and set ptr = lock_ch+1 (mod 4).
REQ-021 On each accept, the next cycle SHALL show dout_valid = 1 and dout/sel/dout_last = accepted data/channel/last; latency is exactly 1 cycle.
REQ-022 When dout_valid=1 and dout_ready=1 with no new accept, the next cycle SHALL show dout_valid = 0; dout, sel and dout_last SHALL hold their values.
REQ-023 Simultaneous downstream pop and upstream accept SHALL sustain full throughput with no bubble: 1 beat/cycle.
REQ-024 When dout_valid=1 and dout_ready=0, dout, sel and dout_last SHALL stay stable and all din_ready bits SHALL be 0.
REQ-025 ptr SHALL wrap from 3 to 0, and arbitration SHALL NOT change while in LOCK, even if higher-priority channels assert din_valid.
REQ-026 A channel dropping din_valid in mid-packet SHALL keep the FSM in LOCK, with no timeout, until its din_last beat is accepted.

Reset
REQ-027 While rst is high, all din_ready bits SHALL be 0.
REQ-028 On a clock edge with rst high, the block SHALL set:
- dout_valid = 0, dout = 0, sel = 0, dout_last = 0
- ptr = 0, lock_ch = 0, FSM = IDLE
REQ-029 Reset asserted in mid-packet or while holding a beat SHALL discard both; no beat SHALL be presented after reset until a new accept.

Verification
REQ-030 Bench SHALL cover single beat: din_valid=4'b0100, din[2]=8'hA5, din_last[2]=1, dout_ready=1 -> din_ready=4'b0100; next cycle dout_valid=1, dout=8'hA5, sel=2, dout_last=1.
REQ-031 Bench SHALL cover round-robin: all 4 channels always valid with single-beat packets and dout_ready=1 -> sel sequence 0,1,2,3,0,1 on consecutive cycles.
REQ-032 Bench SHALL cover packet lock: ch1 sends 3 beats (last on beat 3) while ch0 stays valid -> sel=1,1,1, then 2 if ch2 is valid else 3 else 0; ch0 din_ready is 0 throughout the ch1 packet.
REQ-033 Bench SHALL cover backpressure: dout_ready=0 for 5 cycles with a beat held -> dout/sel stable, din_ready=4'b0000; on release the held beat pops and the next accept occurs in the same cycle.
REQ-034 Bench SHALL cover wrap: ptr=3, din_valid=4'b0011 -> channel 0 wins, then channel 1.
REQ-035 Bench SHALL cover reset mid-packet: rst=1 for 1 cycle during LOCK on ch3 -> dout_valid=0, sel=0; with din_valid=4'b1001 afterwards, channel 0 wins first.
